// File: rtl/div_iter_e.sv
// div_iter_e: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit is produced per cycle from a WIDTH+1-bit partial remainder.
// Sign handling is done on magnitudes, with a fix-up when the result is written.
// The stall output holds the pipeline until the result is ready for HI/LO.
// Optional build macro DIV_EARLY_EXIT_EN: when defined, a zero dividend or zero
// divisor skips the iteration and goes straight from PREP to DONE.
module div_iter_e #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Raw operands captured on the accepting edge; later input changes are ignored.
    logic [WIDTH-1:0] a_raw_reg;
    logic [WIDTH-1:0] b_raw_reg;
    logic             signed_reg;

    // Working registers of the iteration.
    logic [WIDTH-1:0] quo_reg;       // dividend bits shift out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] rem_reg;       // partial remainder (always < divisor, so WIDTH bits suffice)
    logic [WIDTH-1:0] dvs_reg;       // divisor magnitude
    logic [CW-1:0]    cnt_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div_zero_reg;

    // Architectural results.
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             done_reg;

    // Control strobes from the FSM.
    logic accept;        // operands are captured and PREP is entered
    logic load_result;   // results are written; DONE is entered

    // Magnitudes of the captured operands (negation of the most negative value wraps to itself,
    // which read as unsigned is exactly 2^(WIDTH-1)).
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One restoring step.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef DIV_EARLY_EXIT_EN
    logic prep_zero;
    assign prep_zero = (b_raw_reg == '0) || (a_raw_reg == '0);
`endif

    assign a_mag = (signed_reg && a_raw_reg[WIDTH-1]) ? -a_raw_reg : a_raw_reg;
    assign b_mag = (signed_reg && b_raw_reg[WIDTH-1]) ? -b_raw_reg : b_raw_reg;

    // Shift in the next dividend bit and trial-subtract the divisor; keep the difference if non-negative.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_reg};
        fits     = ~diff[WIDTH];
        rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_reg[WIDTH-2:0], fits};
        fin_q    = neg_q_reg ? -quo_step : quo_step;
        fin_r    = neg_r_reg ? -rem_step : rem_step;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and status outputs; cancel overrides every transition.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        load_result = 1'b0;
        busy        = (state_reg == S_PREP) || (state_reg == S_CALC);
        stall       = (start && (state_reg == S_IDLE)) || busy;
        if (cancel) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_PREP;
                        accept     = 1'b1;
                    end
                end
                S_PREP: begin
`ifdef DIV_EARLY_EXIT_EN
                    if (prep_zero) begin
                        state_next  = S_DONE;
                        load_result = 1'b1;
                    end else begin
                        state_next = S_CALC;
                    end
`else
                    state_next = S_CALC;
`endif
                end
                S_CALC: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next  = S_DONE;
                        load_result = 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_next = S_PREP;
                        accept     = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Operand capture on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_raw_reg  <= '0;
            b_raw_reg  <= '0;
            signed_reg <= 1'b0;
        end else if (accept) begin
            a_raw_reg  <= dividend;
            b_raw_reg  <= divisor;
            signed_reg <= signed_div;
        end
    end

    // PREP loads magnitudes and sign flags; CALC advances one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_reg      <= '0;
            rem_reg      <= '0;
            dvs_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (state_reg == S_PREP) begin
            quo_reg      <= a_mag;
            rem_reg      <= '0;
            dvs_reg      <= b_mag;
            cnt_reg      <= '0;
            neg_q_reg    <= signed_reg && (a_raw_reg[WIDTH-1] ^ b_raw_reg[WIDTH-1]);
            neg_r_reg    <= signed_reg && a_raw_reg[WIDTH-1];
            div_zero_reg <= (b_raw_reg == '0);
        end else if (state_reg == S_CALC) begin
            quo_reg <= quo_step;
            rem_reg <= rem_step;
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Result registers: written only when DONE is entered, held otherwise (including on cancel).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= load_result;
            if (load_result) begin
                if (state_reg == S_PREP) begin
                    // Early exit: zero divisor takes precedence over zero dividend.
                    if (b_raw_reg == '0) begin
                        quotient_reg  <= '1;
                        remainder_reg <= a_raw_reg;
                    end else begin
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                    end
                end else if (div_zero_reg) begin
                    // Divide by zero: all-ones quotient and the untouched dividend, no sign fix-up.
                    quotient_reg  <= '1;
                    remainder_reg <= a_raw_reg;
                end else begin
                    quotient_reg  <= fin_q;
                    remainder_reg <= fin_r;
                end
            end
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_div_iter_e.sv
// tb_div_iter_e: scoreboard bench for div_iter_e. A driver issues divides and pushes the
// reference result; a monitor pops and compares whenever done pulses.
module tb_div_iter_e;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_div = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         stall;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           se;
        int           lat;
    } exp_t;

    exp_t sb[$];

    div_iter_e #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on integers. SV division truncates toward zero like MIPS DIV,
    // and in 64-bit arithmetic the most negative / -1 case simply wraps when truncated to 32 bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sbv;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = W'(sa / sbv);
            r   = W'(sa % sbv);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_EXIT_EN
        if (a == 0 || b == 0) return 2;
        return W + 2;
`else
        if (a == 0 && b == 0) return W + 2;
        return W + 2;
`endif
    endfunction

    // Issue one divide and wait for its done pulse. With b2b=1 the caller is in the DONE
    // cycle of the previous divide and start is raised there.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit b2b);
        exp_t e;
        int   lows;
        bit   seen;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        dividend   = a;
        divisor    = b;
        signed_div = s;
        start      = 1'b1;
        model(a, b, s, e.q, e.r);
        e.se  = cyc + 1;
        e.lat = exp_lat(a, b);
        sb.push_back(e);
        if (!b2b) begin
            @(negedge clk);
            chk("stall_start_cycle", {31'd0, stall}, 32'd1);
        end else begin
            chk("stall_in_done", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!stall) lows++;
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
        chk("stall_held", W'(lows), 32'd0);
        last_q = e.q;
        last_r = e.r;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got=done expected=no_done q=%h r=%h", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("latency", W'(cyc - e.se + 1), W'(e.lat));
                    chk("stall_done", {31'd0, stall}, 32'd0);
                    chk("busy_done", {31'd0, busy}, 32'd0);
                    $display("txn q=%h r=%h lat=%0d", quotient, remainder, cyc - e.se + 1);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           m;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        issue(32'd5, 32'd0, 1'b0, 1'b0);
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
        issue(32'd0, 32'd3, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'd3, 1'b0, 1'b0);

        // Back-to-back: start raised during the DONE cycle.
        issue(32'd12345, 32'd67, 1'b0, 1'b1);
        issue(32'hFFFF_8000, 32'd100, 1'b1, 1'b1);

        // Cancel in CALC cycle 10: idle next edge, no done, previous results held.
        @(posedge clk);
        #1;
        dividend = 32'd999; divisor = 32'd10; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hold_q", quotient, last_q);
        chk("cancel_hold_r", remainder, last_r);

        // Cancel together with start in IDLE: the start is dropped.
        dividend = 32'd50; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        chk("cancel_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        chk("cancel_no_result_q", quotient, last_q);

        // Recovery after cancel.
        issue(32'd999, 32'd10, 1'b0, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(posedge clk);
        #1;
        dividend = 32'd77; divisor = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_q = '0;
        last_r = '0;

        // Randomized divides with a mix of signs, small and zero divisors.
        for (int k = 0; k < 24; k++) begin
            m = $urandom_range(0, 7);
            a = (m == 3) ? W'($urandom_range(0, 200)) : W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = -W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            issue(a, b, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Drain: every expectation must have been consumed.
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
